// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit scheduler slice.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int BYTE_W      = 8;
    localparam int FRAME_CNT_W = 16;

    // Width of a requester index; never collapses to zero bits.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake plus the dintx/newd/donetx pins of the shared UART.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uart_ctrl_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_done;
    logic [BYTE_W-1:0]         dintx;
    logic                      newd;
    logic                      donetx;

    modport master (
        output req_valid, req_data, donetx,
        input  req_ready, req_done, dintx, newd
    );

    modport slave (
        input  req_valid, req_data, donetx,
        output req_ready, req_done, dintx, newd
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDW-1:0]     gnt_id,
    output logic               any_req
);

    localparam int SW = IDW + 1;

    logic [SW-1:0] pos_s;
    logic          found_s;

    assign any_req = |req_valid;

    // Walk ptr, ptr+1, ... (mod NUM_REQ) and keep the first valid position.
    always_comb begin
        gnt_id     = {IDW{1'b0}};
        gnt_onehot = {NUM_REQ{1'b0}};
        found_s    = 1'b0;
        pos_s      = {SW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_s = {1'b0, ptr} + SW'(k);
            if (pos_s >= SW'(NUM_REQ)) begin
                pos_s = pos_s - SW'(NUM_REQ);
            end else begin
                pos_s = pos_s;
            end
            if (!found_s && req_valid[pos_s[IDW-1:0]]) begin
                found_s = 1'b1;
                gnt_id  = pos_s[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id;
        end else begin
            gnt_onehot = {NUM_REQ{1'b0}};
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler feeding one UART transmitter: grant, wait for donetx
// (or watchdog), then hold an idle gap before the next grant.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                    clk,
    input  logic                    rst_n,
    uart_tx_arbiter_if.slave        bus,
    output logic                    busy,
    output logic [id_w(NUM_REQ)-1:0] grant_id,
    output logic                    err_timeout,
    output logic [FRAME_CNT_W-1:0]  frame_cnt
);

    localparam int IDW  = id_w(NUM_REQ);
    localparam int TOW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t               state_r, state_nx_s;
    logic [IDW-1:0]       ptr_r;
    logic [TOW-1:0]       to_cnt_r;
    logic [GW-1:0]        gap_cnt_r;
    logic [NUM_REQ-1:0]   req_ready_r, req_done_r;
    logic [BYTE_W-1:0]    dintx_r;
    logic                 newd_r, busy_r, err_timeout_r;
    logic [IDW-1:0]       grant_id_r;
    logic [FRAME_CNT_W-1:0] frame_cnt_r;

    logic [NUM_REQ-1:0]   gnt_onehot_s;
    logic [IDW-1:0]       gnt_id_s;
    logic                 any_req_s;
    logic                 to_hit_s, gap_hit_s;
    logic                 grant_s, done_s, tout_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
        .req_valid  (bus.req_valid),
        .ptr        (ptr_r),
        .gnt_onehot (gnt_onehot_s),
        .gnt_id     (gnt_id_s),
        .any_req    (any_req_s)
    );

    assign to_hit_s  = (to_cnt_r == TOW'(TIMEOUT_CYCLES - 1));
    assign gap_hit_s = (gap_cnt_r == GW'(GAP_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a donetx in the watchdog's last cycle still counts.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) state_nx_s = ST_WAIT;
                else           state_nx_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (bus.donetx || to_hit_s) state_nx_s = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                else                        state_nx_s = ST_WAIT;
            end
            ST_GAP: begin
                if (gap_hit_s) state_nx_s = ST_IDLE;
                else           state_nx_s = ST_GAP;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode: which event the current state produces on this edge.
    always_comb begin
        grant_s = 1'b0;
        done_s  = 1'b0;
        tout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                grant_s = any_req_s;
            end
            ST_WAIT: begin
                done_s = bus.donetx;
                tout_s = !bus.donetx && to_hit_s;
            end
            ST_GAP: begin
                grant_s = 1'b0;
            end
            default: begin
                grant_s = 1'b0;
            end
        endcase
    end

    // Registered outputs, round-robin pointer and the wait/gap counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r   <= {NUM_REQ{1'b0}};
            req_done_r    <= {NUM_REQ{1'b0}};
            newd_r        <= 1'b0;
            err_timeout_r <= 1'b0;
            busy_r        <= 1'b0;
            dintx_r       <= {BYTE_W{1'b0}};
            grant_id_r    <= {IDW{1'b0}};
            ptr_r         <= {IDW{1'b0}};
            frame_cnt_r   <= {FRAME_CNT_W{1'b0}};
            to_cnt_r      <= {TOW{1'b0}};
            gap_cnt_r     <= {GW{1'b0}};
        end else begin
            req_ready_r   <= grant_s ? gnt_onehot_s : {NUM_REQ{1'b0}};
            req_done_r    <= done_s ? (ONE_HOT0 << grant_id_r) : {NUM_REQ{1'b0}};
            newd_r        <= grant_s;
            err_timeout_r <= tout_s;
            busy_r        <= (state_nx_s != ST_IDLE);
            if (grant_s) begin
                dintx_r    <= bus.req_data[int'(gnt_id_s)*BYTE_W +: BYTE_W];
                grant_id_r <= gnt_id_s;
                ptr_r      <= (gnt_id_s == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : gnt_id_s + IDW'(1);
            end
            if (done_s) begin
                frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
            end
            if (grant_s) begin
                to_cnt_r <= {TOW{1'b0}};
            end else if (state_r == ST_WAIT) begin
                to_cnt_r <= to_cnt_r + TOW'(1);
            end
            if (state_r == ST_WAIT) begin
                gap_cnt_r <= {GW{1'b0}};
            end else if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r + GW'(1);
            end
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.req_done  = req_done_r;
    assign bus.newd      = newd_r;
    assign bus.dintx     = dintx_r;
    assign busy          = busy_r;
    assign grant_id      = grant_id_r;
    assign err_timeout   = err_timeout_r;
    assign frame_cnt     = frame_cnt_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench: a timestamp-based model predicts every grant and
// frame completion; a monitor compares whenever the DUT pulses an output.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    import uart_ctrl_pkg::*;

    localparam int N = 4, G = 16, T = 2048, T0 = 64;

    logic clk = 1'b0, rst_n = 1'b0, rst0_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus();
    uart_tx_arbiter_if #(.NUM_REQ(N)) bus0();
    logic busy, err_timeout, busy0, err0;
    logic [1:0] grant_id, gid0;
    logic [15:0] frame_cnt, fcnt0;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
        .grant_id(grant_id), .err_timeout(err_timeout), .frame_cnt(frame_cnt));

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0), .TIMEOUT_CYCLES(T0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .bus(bus0), .busy(busy0),
        .grant_id(gid0), .err_timeout(err0), .frame_cnt(fcnt0));

    typedef struct { int id; logic [7:0] data; int cyc; } grant_exp_t;
    typedef struct { bit tout; int id; logic [15:0] cnt; int cyc; } done_exp_t;

    grant_exp_t grant_q[$];
    done_exp_t  done_q[$];
    int seen_ids[$];

    int checks = 0, errors = 0, cyc = 0;
    int m_ptr, m_elig, m_c, m_wait_end, m_done_cyc, force_tout;
    logic [15:0] m_cnt;
    bit m_busy, m_tout_mode, fair_mode, rand_en, rec_ids, done0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_req_done"}, bus.req_done, 0);
        chk({tag, "_newd"}, bus.newd, 0);
        chk({tag, "_dintx"}, bus.dintx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    // One cycle of requesters + UART stub + reference scheduler.
    task automatic step();
        bit in_wait;
        int g, d;
        grant_exp_t ge_t;
        done_exp_t  de_t;
        @(negedge clk);
        bus.donetx = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.req_ready[i]) bus.req_valid[i] = 1'b0;
            if (!bus.req_valid[i]) begin
                if (fair_mode) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_data[8*i +: 8] = 8'h10 + 8'(i);
                end else if (rand_en && $urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_data[8*i +: 8] = 8'($urandom);
                end
            end
        end
        in_wait = m_busy && cyc >= m_c && cyc <= m_wait_end;
        if (m_busy && !m_tout_mode && cyc == m_done_cyc) bus.donetx = 1'b1;
        else if (!in_wait && $urandom_range(0, 7) == 0) bus.donetx = 1'b1;
        if (m_busy && cyc >= m_elig) m_busy = 1'b0;
        if (!m_busy && cyc >= m_elig && (|bus.req_valid)) begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            ge_t.id = g; ge_t.data = bus.req_data[8*g +: 8]; ge_t.cyc = cyc + 1;
            grant_q.push_back(ge_t);
            m_ptr = (g + 1) % N;
            m_busy = 1'b1;
            m_c = cyc + 1;
            de_t.id = g;
            if (force_tout > 0) begin
                force_tout--;
                m_tout_mode = 1'b1;
                m_wait_end = m_c + T - 1;
                m_elig = m_c + T + G;
                de_t.tout = 1'b1; de_t.cnt = m_cnt; de_t.cyc = m_c + T;
            end else begin
                d = $urandom_range(0, 40);
                m_tout_mode = 1'b0;
                m_done_cyc = m_c + d;
                m_wait_end = m_done_cyc;
                m_elig = m_done_cyc + 1 + G;
                m_cnt = m_cnt + 16'd1;
                de_t.tout = 1'b0; de_t.cnt = m_cnt; de_t.cyc = m_done_cyc + 1;
            end
            done_q.push_back(de_t);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT pulses.
    grant_exp_t ge;
    done_exp_t  de;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.newd) begin
                chk("grant_expected", grant_q.size() > 0, 1'b1);
                if (grant_q.size() > 0) begin
                    ge = grant_q.pop_front();
                    chk("grant_id", grant_id, ge.id);
                    chk("dintx", bus.dintx, ge.data);
                    chk("req_ready", bus.req_ready, 1 << ge.id);
                    chk("grant_cycle", cyc, ge.cyc);
                    if (rec_ids) seen_ids.push_back(int'(grant_id));
                end
            end else if (bus.req_ready != '0) begin
                chk("ready_without_newd", bus.req_ready, 0);
            end
            if (grant_q.size() > 0 && cyc > grant_q[0].cyc) begin
                chk("grant_missing", cyc, grant_q[0].cyc);
                void'(grant_q.pop_front());
            end
            if (bus.req_done != '0 || err_timeout) begin
                chk("completion_expected", done_q.size() > 0, 1'b1);
                if (done_q.size() > 0) begin
                    de = done_q.pop_front();
                    chk("err_timeout", err_timeout, de.tout);
                    chk("req_done", bus.req_done, de.tout ? 0 : (1 << de.id));
                    chk("frame_cnt", frame_cnt, de.cnt);
                    chk("completion_cycle", cyc, de.cyc);
                    chk("busy_in_gap", busy, 1);
                end
            end
            if (done_q.size() > 0 && cyc > done_q[0].cyc) begin
                chk("completion_missing", cyc, done_q[0].cyc);
                void'(done_q.pop_front());
            end
        end
    end

    // Zero-gap instance: back-to-back spacing and a short watchdog.
    initial begin
        int n;
        bit found;
        done0 = 1'b0;
        bus0.req_valid = '0; bus0.req_data = '0; bus0.donetx = 1'b0;
        repeat (3) @(negedge clk);
        rst0_n = 1'b1;
        bus0.req_valid = 4'b0110;
        bus0.req_data = {8'h00, 8'hC3, 8'h3C, 8'h00};
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus0.newd) begin found = 1'b1; break; end
        end
        chk("gap0_first_newd", found, 1);
        chk("gap0_first_data", bus0.dintx, 8'h3C);
        chk("gap0_first_id", gid0, 1);
        bus0.req_valid[1] = 1'b0;
        repeat (4) @(negedge clk);
        bus0.donetx = 1'b1;
        @(negedge clk);
        bus0.donetx = 1'b0;
        chk("gap0_req_done", bus0.req_done, 4'b0010);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); n++;
            if (bus0.newd) break;
        end
        chk("gap0_spacing", n, 1);
        chk("gap0_second_data", bus0.dintx, 8'hC3);
        chk("gap0_second_id", gid0, 2);
        bus0.req_valid[2] = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); n++;
            if (err0) break;
        end
        chk("gap0_timeout_latency", n, T0);
        chk("gap0_timeout_no_done", bus0.req_done, 0);
        chk("gap0_timeout_frame_cnt", fcnt0, 1);
        done0 = 1'b1;
    end

    initial begin
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        bit found;
        bus.req_valid = '0; bus.req_data = '0; bus.donetx = 1'b0;
        m_ptr = 0; m_cnt = 16'd0; m_busy = 1'b0; m_elig = 0; m_c = 0;
        m_wait_end = 0; m_done_cyc = 0; m_tout_mode = 1'b0;
        force_tout = 0; fair_mode = 1'b0; rand_en = 1'b0; rec_ids = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        m_elig = cyc;
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b1;
        bus.req_data[23:16] = 8'hA5;
        repeat (80) step();

        // Random traffic; the first frame is left to the watchdog.
        rand_en = 1'b1;
        force_tout = 1;
        repeat (4000) step();

        // Reset in the middle of a frame, then check fair rotation from 0.
        force_tout = 1;
        found = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            step();
            if (force_tout == 0 && m_busy && m_tout_mode && cyc == m_c + 5) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached_wait_for_reset", found, 1);
        rst_n = 1'b0;
        #1 check_reset("mid");
        grant_q.delete(); done_q.delete();
        bus.req_valid = '0; bus.donetx = 1'b0;
        rand_en = 1'b0;
        m_busy = 1'b0; m_ptr = 0; m_cnt = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_elig = cyc;
        #1 chk("frame_cnt_after_reset", frame_cnt, 0);
        fair_mode = 1'b1;
        seen_ids.delete();
        rec_ids = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step();
            if (seen_ids.size() >= 5) break;
        end
        chk("fair_grants_seen", seen_ids.size() >= 5, 1);
        for (int i = 0; i < 5; i++)
            if (i < seen_ids.size()) chk("fair_order", seen_ids[i], exp_seq[i]);
        rec_ids = 1'b0;
        fair_mode = 1'b0;

        found = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            step();
            if (bus.req_valid == '0 && grant_q.size() == 0 && done_q.size() == 0 && cyc > m_elig) begin
                found = 1'b1;
                break;
            end
        end
        chk("drained", found, 1);
        chk("grant_queue_empty", grant_q.size(), 0);
        chk("completion_queue_empty", done_q.size(), 0);
        chk("gap0_sequence_done", done0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
